// File: rtl/mlp_mac_datapath.sv
// mlp_mac_datapath: neuron-RAM multiply-accumulate consumer of the MLP sequencer strobes.
// Optional macro ROUND_EN: round half up before the Q8.8 rescale (default build truncates).
module mlp_mac_datapath #(
  parameter int DATA_W     = 16,
  parameter int FRAC       = 8,
  parameter int ACC_W      = 40,
  parameter int ADDR_W     = 12,
  parameter int LAST_LAYER = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] input_neuron_addr,
  input  logic [ADDR_W-1:0] output_neuron_addr,
  input  logic [15:0]       input_weight_addr,
  input  logic              reset_mult_acc,
  input  logic              write_neuron,
  input  logic              done,
  output logic [15:0]       weight_addr,
  input  logic [DATA_W-1:0] weight_data,
  input  logic              load_en,
  input  logic [ADDR_W-3:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic              halted
);

  // Strobes are sampled every cycle with no backpressure: each cycle is one
  // term (accumulate), a clear (reset_mult_acc only) or a last term (write_neuron).
  localparam int PROD_W = 2 * DATA_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (DATA_W - 1)));
`ifdef ROUND_EN
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(2 ** (FRAC - 1));
`endif

  logic [DATA_W-1:0]        ram [2**ADDR_W];
  logic [DATA_W-1:0]        n_q;
  logic                     is_last_q;
  logic                     clr_q;
  logic                     done_q;
  logic [ADDR_W-1:0]        out_addr_q;
  logic signed [ACC_W-1:0]  acc;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W-1:0]  rnd_sum;
  logic signed [ACC_W-1:0]  shifted;
  logic [DATA_W-1:0]        sat_val;
  logic [DATA_W-1:0]        wb_data;
  logic                     wb_en;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;

  assign weight_addr = input_weight_addr;

  always_comb begin
    prod     = PROD_W'($signed(n_q)) * PROD_W'($signed(weight_data));
    prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    sum      = acc + prod_ext;
`ifdef ROUND_EN
    rnd_sum  = sum + RND;
`else
    rnd_sum  = sum;
`endif
    shifted  = rnd_sum >>> FRAC;
    if (shifted > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                        sat_val = shifted[DATA_W-1:0];
    // Hidden layers are ReLU-activated; the output layer keeps its sign.
    wb_data = sat_val;
    if (out_addr_q[ADDR_W-1 -: 2] != 2'(LAST_LAYER) && sat_val[DATA_W-1])
      wb_data = '0;
    wb_en   = is_last_q & ~halted;
    // A host load owns the write port over a colliding write-back.
    wr_en   = load_en | wb_en;
    wr_addr = load_en ? {2'b00, load_addr} : out_addr_q;
    wr_data = load_en ? load_data : wb_data;
  end

  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_q        <= '0;
      is_last_q  <= 1'b0;
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      out_addr_q <= '0;
    end else begin
      // Write-first forwarding lets a layer read the neuron written on this edge.
      n_q        <= (wr_en && wr_addr == input_neuron_addr) ? wr_data : ram[input_neuron_addr];
      is_last_q  <= write_neuron;
      clr_q      <= reset_mult_acc & ~write_neuron;
      done_q     <= done;
      out_addr_q <= output_neuron_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc          <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      halted       <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (halted || is_last_q || clr_q) acc <= '0;
      else                              acc <= sum;
      if (wb_en && done_q) begin
        result       <= wb_data;
        result_valid <= 1'b1;
        halted       <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mlp_mac_datapath.sv
// tb_mlp_mac_datapath: drives sequencer-style term streams into mlp_mac_datapath and
// compares neuron RAM and the final result against an arithmetic network model.
module tb_mlp_mac_datapath;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] input_neuron_addr = '0;
  logic [11:0] output_neuron_addr = '0;
  logic [15:0] input_weight_addr = '0;
  logic        reset_mult_acc = 1'b1;
  logic        write_neuron = 1'b0;
  logic        done = 1'b0;
  logic [15:0] weight_addr;
  logic [15:0] weight_data = '0;
  logic        load_en = 1'b0;
  logic [9:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic [15:0] result;
  logic        result_valid;
  logic        halted;

  int n_tests = 0;
  int n_fail = 0;
  int rv_count = 0;
  logic [15:0] exp_q[$];
  logic [15:0] rom [65536];
  logic [15:0] ref_ram [4096];

  mlp_mac_datapath dut (
    .clk(clk), .reset(reset),
    .input_neuron_addr(input_neuron_addr), .output_neuron_addr(output_neuron_addr),
    .input_weight_addr(input_weight_addr), .reset_mult_acc(reset_mult_acc),
    .write_neuron(write_neuron), .done(done),
    .weight_addr(weight_addr), .weight_data(weight_data),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .result(result), .result_valid(result_valid), .halted(halted)
  );

  // Clock and external weight ROM (one cycle read latency).
  always #5 clk = ~clk;
  always @(posedge clk) weight_data <= rom[weight_addr];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard: every result pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (reset && result_valid) begin
      rv_count++;
      if (exp_q.size() == 0) check("unexpected_result", 40'(result), 40'hX_DEAD);
      else check("result", 40'(result), 40'(exp_q.pop_front()));
    end
  end

  // Reference neuron: Q8.8 rescale, saturation, ReLU except on the output layer.
  function automatic logic [15:0] act_ref(input longint sum, input int layer);
    longint s;
    s = sum;
`ifdef ROUND_EN
    s = s + 128;
`endif
    s = s >>> 8;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    if (layer != 3 && s < 0) s = 0;
    return s[15:0];
  endfunction

  task automatic idle(input int n);
    input_neuron_addr = '0; output_neuron_addr = '0; input_weight_addr = '0;
    reset_mult_acc = 1'b1; write_neuron = 1'b0; done = 1'b0; load_en = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input int idx, input logic [15:0] val);
    reset_mult_acc = 1'b1; write_neuron = 1'b0; done = 1'b0;
    load_en = 1'b1; load_addr = 10'(idx); load_data = val;
    @(posedge clk); #1;
    load_en = 1'b0;
    ref_ram[idx] = val;
  endtask

  task automatic load_inputs(input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] c, input logic [15:0] d);
    load(0, a); load(1, b); load(2, c); load(3, d);
    idle(1);
  endtask

  task automatic fill_w(input int base, input int nout, input int nin, input logic [15:0] val);
    for (int j = 0; j < nout; j++)
      for (int k = 0; k < nin; k++) rom[base + j*16 + k] = val;
  endtask

  task automatic term(input int src, input int k, input int dst, input int j, input int wa,
                      input logic last, input logic dn);
    input_neuron_addr = 12'(src*1024 + k);
    output_neuron_addr = 12'(dst*1024 + j);
    input_weight_addr = 16'(wa);
    reset_mult_acc = 1'b0; write_neuron = last; done = dn; load_en = 1'b0;
    @(posedge clk); #1;
  endtask

  // Model the layer from ref_ram, then stream its terms back-to-back.
  task automatic run_layer(input int src, input int dst, input int nin, input int nout,
                           input int wbase, input logic fin);
    longint sum;
    logic dn;
    for (int j = 0; j < nout; j++) begin
      sum = 0;
      for (int k = 0; k < nin; k++)
        sum += longint'($signed(ref_ram[src*1024 + k])) * longint'($signed(rom[wbase + j*16 + k]));
      ref_ram[dst*1024 + j] = act_ref(sum, dst);
    end
    for (int j = 0; j < nout; j++)
      for (int k = 0; k < nin; k++) begin
        dn = fin && (j == nout-1) && (k == nin-1);
        if (dn) exp_q.push_back(ref_ram[dst*1024 + j]);
        term(src, k, dst, j, wbase + j*16 + k, k == nin-1, dn);
      end
  endtask

  task automatic check_ram(input int a);
    check($sformatf("ram_%03h", a), 40'(dut.ram[a]), 40'(ref_ram[a]));
  endtask

  task automatic do_reset();
    idle(1);
    reset = 1'b0;
    #1;
    check("rst_acc", dut.acc, 40'd0);
    check("rst_result_valid", 40'(result_valid), 40'd0);
    check("rst_halted", 40'(halted), 40'd0);
    check("rst_result", 40'(result), 40'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(1);
  endtask

  initial begin
    int rv0;
    logic [15:0] exp_round;
    for (int i = 0; i < 65536; i++) rom[i] = '0;
    for (int i = 0; i < 4096; i++) ref_ram[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    input_weight_addr = 16'hBEEF;
    #1 check("weight_addr_copy", 40'(weight_addr), 40'h0BEEF);

    // Single layer: one positive-weight neuron, one that ReLU clamps.
    load_inputs(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    fill_w(16'h000, 1, 4, 16'h0100);
    fill_w(16'h010, 1, 4, 16'hFF00);
    run_layer(0, 1, 4, 2, 16'h000, 1'b0);
    idle(3);
    check("l1_n0_const", 40'(dut.ram[12'h400]), 40'h0280);
    check("l1_n1_relu", 40'(dut.ram[12'h401]), 40'h0000);
    check_ram(12'h400);

    // Full 4-2-2-1 network ending with the done strobe.
    fill_w(16'h100, 2, 4, 16'h0100);
    fill_w(16'h200, 2, 2, 16'h0100);
    fill_w(16'h300, 1, 2, 16'h0100);
    rv0 = rv_count;
    run_layer(0, 1, 4, 2, 16'h100, 1'b0);
    run_layer(1, 2, 2, 2, 16'h200, 1'b0);
    run_layer(2, 3, 2, 1, 16'h300, 1'b1);
    idle(3);
    check("net_l1", 40'({dut.ram[12'h400], dut.ram[12'h401]}), 40'h0280_0280);
    check("net_l2", 40'({dut.ram[12'h800], dut.ram[12'h801]}), 40'h0500_0500);
    check("net_out", 40'(dut.ram[12'hC00]), 40'h0A00);
    check("net_result", 40'(result), 40'h0A00);
    check("net_pulses", 40'(rv_count - rv0), 40'd1);
    check("net_halted", 40'(halted), 40'd1);
    // Halted: arbitrary strobes must not write, accumulate or pulse.
    for (int i = 0; i < 20; i++)
      term(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(1, 3)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(3);
    check_ram(12'h400); check_ram(12'h401); check_ram(12'h800);
    check_ram(12'h801); check_ram(12'hC00);
    check("halt_acc", dut.acc, 40'd0);
    check("halt_result_held", 40'(result), 40'h0A00);
    check("halt_no_pulse", 40'(rv_count - rv0), 40'd1);

    // Layer boundary with fan-in 1: the next read must see the fresh write.
    do_reset();
    load(0, 16'h0300);
    idle(1);
    fill_w(16'h400, 1, 1, 16'h0100);
    fill_w(16'h500, 1, 1, 16'h0100);
    run_layer(0, 1, 1, 1, 16'h400, 1'b0);
    run_layer(1, 2, 1, 1, 16'h500, 1'b0);
    idle(3);
    check("bypass_l1", 40'(dut.ram[12'h400]), 40'h0300);
    check("bypass_l2", 40'(dut.ram[12'h800]), 40'h0300);

    // Saturation, then a negative output-layer value that skips ReLU.
    do_reset();
    load_inputs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
    fill_w(16'h600, 1, 4, 16'h7FFF);
    run_layer(0, 1, 4, 1, 16'h600, 1'b0);
    idle(3);
    check("sat_pos", 40'(dut.ram[12'h400]), 40'h7FFF);
    load_inputs(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    fill_w(16'h700, 1, 4, 16'hFF00);
    run_layer(0, 3, 4, 1, 16'h700, 1'b1);
    idle(3);
    check("neg_out_result", 40'(result), 40'h0FD80);
    check_ram(12'hC00);

    // Rounding of a 0x180 product sum.
    do_reset();
    load(0, 16'h0001);
    idle(1);
    rom[16'h800] = 16'h0180;
    run_layer(0, 3, 1, 1, 16'h800, 1'b1);
    idle(3);
`ifdef ROUND_EN
    exp_round = 16'h0002;
`else
    exp_round = 16'h0001;
`endif
    check("round_result", 40'(result), 40'(exp_round));

    // Reset pulse in the middle of a neuron.
    do_reset();
    load_inputs(16'h0100, 16'h0200, 16'hFF00, 16'h0080);
    fill_w(16'h900, 1, 4, 16'h0100);
    fill_w(16'hA00, 1, 4, 16'h0200);
    run_layer(0, 1, 4, 1, 16'h900, 1'b0);
    idle(3);
    check("pre_mid_ram", 40'(dut.ram[12'h400]), 40'h0280);
    term(0, 0, 1, 0, 16'hA00, 1'b0, 1'b0);
    term(0, 1, 1, 0, 16'hA01, 1'b0, 1'b0);
    check("mid_acc_partial", dut.acc, 40'h0002_0000);
    reset = 1'b0;
    #1;
    check("mid_acc_cleared", dut.acc, 40'd0);
    check("mid_result_valid", 40'(result_valid), 40'd0);
    check("mid_halted", 40'(halted), 40'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(3);
    check("mid_ram_kept", 40'(dut.ram[12'h400]), 40'h0280);
    run_layer(0, 1, 4, 1, 16'h900, 1'b0);
    idle(3);
    check("mid_rerun", 40'(dut.ram[12'h400]), 40'h0280);

    // Randomized networks with random fan-in against the model.
    for (int it = 0; it < 8; it++) begin
      int s1, s2;
      logic [15:0] v [4];
      do_reset();
      for (int i = 0; i < 4; i++)
        v[i] = (it % 2 == 0) ? 16'(int'($urandom_range(0, 1536)) - 768)
                             : 16'($urandom_range(0, 65535));
      load_inputs(v[0], v[1], v[2], v[3]);
      s1 = int'($urandom_range(1, 4));
      s2 = int'($urandom_range(1, 4));
      for (int a = 16'h1000; a < 16'h1300; a++)
        rom[a] = (it % 2 == 0) ? 16'(int'($urandom_range(0, 1024)) - 512)
                               : 16'($urandom_range(0, 65535));
      rv0 = rv_count;
      run_layer(0, 1, 4, s1, 16'h1000, 1'b0);
      run_layer(1, 2, s1, s2, 16'h1100, 1'b0);
      run_layer(2, 3, s2, 1, 16'h1200, 1'b1);
      idle(3);
      for (int j = 0; j < s1; j++) check_ram(12'h400 + j);
      for (int j = 0; j < s2; j++) check_ram(12'h800 + j);
      check_ram(12'hC00);
      check("rnd_pulses", 40'(rv_count - rv0), 40'd1);
      check("rnd_halted", 40'(halted), 40'd1);
    end

    idle(2);
    check("exp_q_drained", 40'(exp_q.size()), 40'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mlp_mac_datapath.md
Name: mlp_mac_datapath

Overview:
- Consumer end of the MLP sequencer's address/strobe interface.
- Each cycle it takes the presented neuron address, weight address and strobes, reads the neuron from an internal layered neuron RAM and the weight from the external weight ROM, and multiply-accumulates them.
- When the sequencer marks a neuron's final term, it writes the activated, saturated sum back to neuron RAM. On the final-layer write it presents the MLP result to the softmax stage.

Parameters:
- DATA_W, 16, signed neuron/weight width (Q8.8)
- FRAC, 8, fractional bits
- ACC_W, 40, accumulator width
- ADDR_W, 12, neuron RAM address width; top 2 bits = layer, low 10 bits = index
- LAST_LAYER, 3, layer index that receives no ReLU

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- input_neuron_addr  in  12  neuron read address
- output_neuron_addr  in  12  neuron write-back address
- input_weight_addr  in  16  weight address
- reset_mult_acc  in  1  accumulation-boundary strobe
- write_neuron  in  1  final-term / write-back strobe
- done  in  1  final-layer strobe
- weight_addr  out  16  to weight ROM; combinational copy of input_weight_addr
- weight_data  in  16  ROM data, valid 1 cycle after weight_addr
- load_en  in  1  input-layer load strobe
- load_addr  in  10  input neuron index (layer 0)
- load_data  in  16  input neuron value
- result  out  16  final output neuron value
- result_valid  out  1  one-cycle pulse with result
- halted  out  1  high after final write until reset

Behaviour:
- Reset (reset=0, async): stage-1 registers, accumulator, result=0, result_valid=0 and halted=0 are all cleared. Neuron RAM contents are not cleared.
- Neuron RAM: 4096 x 16, synchronous read, one write port.
- Pipeline, for inputs presented in cycle t:
  - Edge ending t: read data n_q is registered; stage 1 registers term_valid, is_last, clr, out_addr and done_q.
  - Cycle t+1: product p = n_q * weight_data (signed 32-bit), sign-extended to ACC_W.
  - Edge ending t+1: accumulate/write-back. Total latency from a term to its write is 2 edges.
- Term classification:
  - write_neuron=1: last term.
  - reset_mult_acc=1 and write_neuron=0: clear cycle; acc<=0, term discarded.
  - Otherwise: acc<=acc+p.
- Last term:
  - sum=acc+p; s=sum>>>FRAC (arithmetic shift).
  - Saturate s to [-32768, 32767].
  - If out_addr[11:10]!=LAST_LAYER, apply ReLU (negative -> 0).
  - Write to RAM[out_addr]; acc<=0.
- Read-during-write bypass: if the write address equals the read address being registered on the same edge, n_q takes the write data (write-first). This covers the next-layer read that immediately follows the previous layer's last write.
- done:
  - A last term with done_q=1 writes normally, sets result and result_valid=1 for exactly one cycle, and sets halted=1.
  - While halted: all terms ignored, no RAM writes, acc held at 0, result held.
- Load:
  - load_en writes RAM[{2'b00, load_addr}]<=load_data.
  - Legal only while the sequencer is held in reset or halted=1.
  - If it collides with a write-back, the load wins and the write-back is dropped.
- Sequencer in reset (reset_mult_acc=1, write_neuron=0) is a continuous clear; no writes occur.
- Reset asserted mid-neuron: the partial accumulation is lost; RAM keeps any completed writes.

Optional Feature:
- ROUND_EN
  - Defined: adds 1<<(FRAC-1) to sum before the shift (round half up), then saturates.
  - Undefined: truncating arithmetic shift only.

Test Plan:
- Load inputs 0x0100, 0x0200, 0xFF00, 0x0080 (1, 2, -1, 0.5). Neuron 0 of layer 1 weights all 0x0100 -> RAM[0x400]=0x0280. Neuron 1 weights all 0xFF00 -> RAM[0x401]=0x0000 (ReLU).
- Full 4-2-2-1 run with all weights 0x0100 and inputs as above:
  - Layer 1 = 0x0280, 0x0280.
  - Layer 2 = 0x0500, 0x0500.
  - Output = 0x0A00; result_valid pulses once with result=0x0A00; halted=1; no further writes over 20 extra cycles.
- Back-to-back layer boundary, fan-in 1 into a single neuron: bypass must forward the just-written value. RAM read of the same address on the same edge returns the new data, not the stale data.
- Saturation: inputs 0x7FFF x4, weights 0x7FFF -> written value 0x7FFF. Output layer with negative inputs yields a negative raw value (no ReLU), e.g. 0xFD80.
- ROUND_EN: product sum 0x0000_0180 -> 0x0002 with the macro, 0x0001 without.
- reset pulse mid-neuron (after 2 of 4 terms): acc, result_valid and halted are 0 immediately (async). RAM[0x400] is unchanged. After reset, rerunning produces 0x0280.
